io_cell_bank: RTL and testbench

Parametrised N-channel GPIO pad bank controller. Sits between core logic and the per-pad bidirectional cells (one io_cell per channel, instantiated at top level).

---
 rtl/io_cell_bank_pkg.sv | 15 +
 rtl/io_in_filter.sv | 60 ++++++
 rtl/io_cell_bank.sv | 71 +++++++
 tb/tb_io_cell_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_cell_bank_pkg.sv
// Shared constants and types for the io_cell_bank GPIO pad controller.
package io_cell_bank_pkg;

  localparam int FILT_W_DEF = 4;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  typedef struct packed {
    logic dir;
    logic rise_en;
    logic fall_en;
  } ch_cfg_t;

endpackage

// File: rtl/io_in_filter.sv
// One input channel: synchroniser chain, glitch filter and edge detect.
module io_in_filter
  import io_cell_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dir,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              pad,
  output logic              f,
  output logic              rise_pulse,
  output logic              fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt;
  logic                   s;
  logic                   accept;

  assign s = sync_q[SYNC_STAGES-1];

  // The chain runs regardless of direction so an input switch sees a settled value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Using >= lets a shortened filter length take effect on the very next cycle.
  always_comb begin
    accept = (dir == DIR_IN) && (s != f) && (cnt >= filt_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (dir == DIR_OUT) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (s == f) begin
      cnt <= '0;
    end else if (accept) begin
      f   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + FILT_W'(1);
    end
  end

  // Pulses are valid in the cycle before f updates so pending sets land with f.
  assign rise_pulse = accept & s;
  assign fall_pulse = accept & ~s;

endmodule

// File: rtl/io_cell_bank.sv
// N-channel GPIO bank: registered pad drive, filtered inputs, sticky edge interrupts.
module io_cell_bank
  import io_cell_bank_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] cfg_dir_i,
  input  logic [FILT_W-1:0] cfg_filt_len_i,
  input  logic [NUM_CH-1:0] cfg_rise_en_i,
  input  logic [NUM_CH-1:0] cfg_fall_en_i,
  input  logic [NUM_CH-1:0] core_out_i,
  output logic [NUM_CH-1:0] core_in_o,
  input  logic [NUM_CH-1:0] irq_clr_i,
  output logic [NUM_CH-1:0] irq_pend_o,
  output logic              irq_o,
  output logic [NUM_CH-1:0] pad_o,
  output logic [NUM_CH-1:0] pad_oe_o,
  input  logic [NUM_CH-1:0] pad_i
);

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] pend_set;
  ch_cfg_t           ch_cfg [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_cfg[i] = '{dir: cfg_dir_i[i], rise_en: cfg_rise_en_i[i], fall_en: cfg_fall_en_i[i]};

    io_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .dir        (ch_cfg[i].dir),
      .filt_len   (cfg_filt_len_i),
      .pad        (pad_i[i]),
      .f          (core_in_o[i]),
      .rise_pulse (rise[i]),
      .fall_pulse (fall[i])
    );

    assign pend_set[i] = (rise[i] & ch_cfg[i].rise_en) | (fall[i] & ch_cfg[i].fall_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_oe_o <= '0;
      pad_o    <= '0;
    end else begin
      pad_oe_o <= ~cfg_dir_i;
      pad_o    <= ~cfg_dir_i & core_out_i;
    end
  end

  // A new event in the same cycle as a clear survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend_o <= '0;
    end else begin
      irq_pend_o <= (irq_pend_o & ~irq_clr_i) | pend_set;
    end
  end

  assign irq_o = |irq_pend_o;

endmodule

// File: tb/tb_io_cell_bank.sv
// Directed-vector bench for io_cell_bank with hand-computed expectations.
module tb_io_cell_bank;

  localparam int NUM_CH = 8;
  localparam int FILT_W = 4;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] cfg_dir_i;
  logic [FILT_W-1:0] cfg_filt_len_i;
  logic [NUM_CH-1:0] cfg_rise_en_i;
  logic [NUM_CH-1:0] cfg_fall_en_i;
  logic [NUM_CH-1:0] core_out_i;
  logic [NUM_CH-1:0] core_in_o;
  logic [NUM_CH-1:0] irq_clr_i;
  logic [NUM_CH-1:0] irq_pend_o;
  logic              irq_o;
  logic [NUM_CH-1:0] pad_o;
  logic [NUM_CH-1:0] pad_oe_o;
  logic [NUM_CH-1:0] pad_i;

  int n_checks;
  int n_errors;

  io_cell_bank #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (2),
    .FILT_W      (FILT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_dir_i      (cfg_dir_i),
    .cfg_filt_len_i (cfg_filt_len_i),
    .cfg_rise_en_i  (cfg_rise_en_i),
    .cfg_fall_en_i  (cfg_fall_en_i),
    .core_out_i     (core_out_i),
    .core_in_o      (core_in_o),
    .irq_clr_i      (irq_clr_i),
    .irq_pend_o     (irq_pend_o),
    .irq_o          (irq_o),
    .pad_o          (pad_o),
    .pad_oe_o       (pad_oe_o),
    .pad_i          (pad_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_pend(input logic [NUM_CH-1:0] mask);
    irq_clr_i = mask;
    tick(1);
    irq_clr_i = '0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    cfg_dir_i      = '0;
    cfg_filt_len_i = '0;
    cfg_rise_en_i  = '0;
    cfg_fall_en_i  = '0;
    core_out_i     = '0;
    irq_clr_i      = '0;
    pad_i          = '0;

    tick(2);
    check_eq("rst_pad_oe", 32'(pad_oe_o), 32'h00);
    check_eq("rst_pad_o", 32'(pad_o), 32'h00);
    check_eq("rst_core_in", 32'(core_in_o), 32'h00);
    check_eq("rst_pend", 32'(irq_pend_o), 32'h00);
    check_eq("rst_irq", 32'(irq_o), 32'h0);
    rst_n = 1'b1;

    // output drive
    cfg_dir_i  = 8'h0F;
    core_out_i = 8'hA5;
    tick(1);
    check_eq("out_pad_oe", 32'(pad_oe_o), 32'hF0);
    check_eq("out_pad_o", 32'(pad_o), 32'hA0);
    check_eq("out_core_in", 32'(core_in_o), 32'h00);
    pad_i = 8'hFF;
    tick(4);
    check_eq("out_ch_reads0", 32'(core_in_o), 32'h0F);
    pad_i = 8'h00;
    tick(4);
    check_eq("in_fall_back", 32'(core_in_o), 32'h00);

    // filter latency: 2 sync + 3 + 1 = 6 edges
    cfg_dir_i      = 8'hFF;
    cfg_filt_len_i = 4'd3;
    cfg_rise_en_i  = 8'h01;
    tick(1);
    check_eq("all_in_pad_oe", 32'(pad_oe_o), 32'h00);
    check_eq("all_in_pad_o", 32'(pad_o), 32'h00);
    pad_i = 8'h01;
    tick(5);
    check_eq("lat_early_core", 32'(core_in_o), 32'h00);
    check_eq("lat_early_irq", 32'(irq_o), 32'h0);
    tick(1);
    check_eq("lat_core", 32'(core_in_o), 32'h01);
    check_eq("lat_irq", 32'(irq_o), 32'h1);
    check_eq("lat_pend", 32'(irq_pend_o), 32'h01);
    clear_pend(8'h01);
    check_eq("clr0_pend", 32'(irq_pend_o), 32'h00);

    // glitch of 3 cycles rejected, 4 cycles accepted
    cfg_rise_en_i = 8'h04;
    cfg_fall_en_i = 8'h04;
    pad_i = 8'h05;
    tick(3);
    pad_i = 8'h01;
    tick(8);
    check_eq("glitch_core", 32'(core_in_o), 32'h01);
    check_eq("glitch_pend", 32'(irq_pend_o), 32'h00);
    pad_i = 8'h05;
    tick(4);
    pad_i = 8'h01;
    tick(2);
    check_eq("pulse4_core", 32'(core_in_o), 32'h05);
    check_eq("pulse4_pend", 32'(irq_pend_o), 32'h04);
    tick(4);
    check_eq("pulse4_fall_core", 32'(core_in_o), 32'h01);
    check_eq("pulse4_fall_pend", 32'(irq_pend_o), 32'h04);
    clear_pend(8'h04);
    check_eq("clr2_pend", 32'(irq_pend_o), 32'h00);
    check_eq("clr2_irq", 32'(irq_o), 32'h0);

    // set/clear collision on ch1 (filter length 0 -> 3 edge latency)
    cfg_filt_len_i = 4'd0;
    cfg_rise_en_i  = 8'h02;
    cfg_fall_en_i  = 8'h02;
    pad_i = 8'h03;
    tick(3);
    check_eq("col_rise_core", 32'(core_in_o), 32'h03);
    check_eq("col_rise_pend", 32'(irq_pend_o), 32'h02);
    pad_i = 8'h01;
    tick(2);
    clear_pend(8'h02);
    check_eq("col_fall_core", 32'(core_in_o), 32'h01);
    check_eq("col_set_wins", 32'(irq_pend_o), 32'h02);
    clear_pend(8'h02);
    check_eq("col_lone_clr", 32'(irq_pend_o), 32'h00);
    check_eq("col_lone_irq", 32'(irq_o), 32'h0);

    // direction switch on ch3
    cfg_rise_en_i = 8'h08;
    cfg_fall_en_i = 8'h08;
    pad_i = 8'h09;
    tick(3);
    check_eq("dir_pre_core", 32'(core_in_o), 32'h09);
    check_eq("dir_pre_pend", 32'(irq_pend_o), 32'h08);
    clear_pend(8'h08);
    cfg_dir_i = 8'hF7;
    tick(1);
    check_eq("dir_out_core", 32'(core_in_o), 32'h01);
    check_eq("dir_out_pend", 32'(irq_pend_o), 32'h00);
    check_eq("dir_out_oe", 32'(pad_oe_o), 32'h08);
    check_eq("dir_out_pad", 32'(pad_o), 32'h00);
    pad_i = 8'h01;
    tick(3);
    check_eq("dir_out_quiet", 32'(irq_pend_o), 32'h00);
    cfg_filt_len_i = 4'd3;
    cfg_dir_i      = 8'hFF;
    pad_i          = 8'h09;
    tick(5);
    check_eq("dir_back_early", 32'(irq_pend_o), 32'h00);
    tick(1);
    check_eq("dir_back_core", 32'(core_in_o), 32'h09);
    check_eq("dir_back_pend", 32'(irq_pend_o), 32'h08);
    check_eq("dir_back_irq", 32'(irq_o), 32'h1);

    // fill all pending bits, then reset mid-operation
    cfg_filt_len_i = 4'd0;
    cfg_rise_en_i  = 8'hFF;
    cfg_fall_en_i  = 8'h00;
    pad_i = 8'h00;
    tick(4);
    check_eq("all_low_core", 32'(core_in_o), 32'h00);
    check_eq("all_low_pend", 32'(irq_pend_o), 32'h08);
    pad_i = 8'hFF;
    tick(4);
    check_eq("all_high_core", 32'(core_in_o), 32'hFF);
    check_eq("all_high_pend", 32'(irq_pend_o), 32'hFF);
    cfg_rise_en_i = 8'h00;
    tick(1);
    check_eq("en_off_keeps", 32'(irq_pend_o), 32'hFF);
    cfg_dir_i  = 8'h0F;
    core_out_i = 8'hFF;
    tick(1);
    check_eq("mix_pad_oe", 32'(pad_oe_o), 32'hF0);
    check_eq("mix_pad_o", 32'(pad_o), 32'hF0);
    check_eq("mix_core", 32'(core_in_o), 32'h0F);
    check_eq("mix_pend", 32'(irq_pend_o), 32'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pad_oe", 32'(pad_oe_o), 32'h00);
    check_eq("arst_pad_o", 32'(pad_o), 32'h00);
    check_eq("arst_core", 32'(core_in_o), 32'h00);
    check_eq("arst_pend", 32'(irq_pend_o), 32'h00);
    check_eq("arst_irq", 32'(irq_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
